// File: rtl/fp_square_if.sv
// Operand/result handshake bundle for fp_square: valid/ready in, valid/ready out.
interface fp_square_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floating_point_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    modport slave (
        input  in_valid, floating_point_in, out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, floating_point_in, out_ready,
        input  in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_square.sv
// Sequential IEEE-754 single-precision squarer: shift-add mantissa multiply, flush-to-zero.
// Build option FP_SQUARE_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_square (
    input  logic        clk,
    input  logic        rst_n,
    fp_square_if.slave  io
);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    exp_q, exp_d;
    logic [23:0]   man_q, man_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [47:0]   prod_q, prod_d;
    logic [31:0]   res_q, res_d;
    logic [2:0]    flg_q, flg_d;
    logic          ov_q, ov_d;

    logic          accept;
    logic [7:0]    in_exp;
    logic [22:0]   in_man;
    logic          n;
    logic [22:0]   frac, frac_fin;
    logic signed [9:0] e_res, e_fin;
    logic          unused_sign;

    // in_ready is gated by reset so the block never looks ready while held in reset
    assign io.in_ready  = rst_n && (state_q == IDLE);
    assign accept       = io.in_valid && io.in_ready;
    assign in_exp       = io.floating_point_in[30:23];
    assign in_man       = io.floating_point_in[22:0];
    assign unused_sign  = io.floating_point_in[31];

    assign io.out_valid = ov_q;
    assign io.result    = res_q;
    assign io.flags     = flg_q;

    assign n     = prod_q[47];
    assign frac  = n ? prod_q[46:24] : prod_q[45:23];
    assign e_res = $signed({1'b0, exp_q, 1'b0}) - 10'sd127 + $signed({9'd0, n});

`ifdef FP_SQUARE_ROUND_EN
    logic        guard, sticky, rnd_up;
    logic [23:0] frac_rnd;
    assign guard    = n ? prod_q[23] : prod_q[22];
    assign sticky   = n ? (|prod_q[22:0]) : (|prod_q[21:0]);
    assign rnd_up   = guard && (sticky || frac[0]);
    assign frac_rnd = {1'b0, frac} + {23'd0, rnd_up};
    // a carry out of the fraction leaves it all-zero and bumps the exponent
    assign frac_fin = frac_rnd[22:0];
    assign e_fin    = e_res + $signed({9'd0, frac_rnd[23]});
`else
    logic unused_lo;
    assign unused_lo = ^prod_q[22:0];
    assign frac_fin  = frac;
    assign e_fin     = e_res;
`endif

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        man_d   = man_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        res_d   = res_q;
        flg_d   = flg_q;
        // valid trails entry into DONE by one edge and drops on the handshake edge
        ov_d    = (state_q == DONE) && !(ov_q && io.out_ready);
        case (state_q)
            IDLE: if (accept) begin
                exp_d  = in_exp;
                man_d  = {1'b1, in_man};
                cnt_d  = 5'd23;
                prod_d = '0;
                if (in_exp == 8'hFF) begin
                    state_d = DONE;
                    res_d   = (in_man != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
                    flg_d   = (in_man != 0) ? 3'b100 : 3'b000;
                end else if (in_exp == 8'h00) begin
                    state_d = DONE;
                    res_d   = 32'h0;
                    flg_d   = 3'b000;
                end else begin
                    state_d = MUL;
                end
            end
            MUL: begin
                // MSB-first Horner: shift the partial sum, add the multiplicand for this bit
                prod_d = {prod_q[46:0], 1'b0} + (man_q[cnt_q] ? {24'd0, man_q} : 48'd0);
                if (cnt_q == 5'd0) state_d = NORM;
                else               cnt_d   = cnt_q - 5'd1;
            end
            NORM: begin
                state_d = DONE;
                if (e_fin >= 10'sd255) begin
                    res_d = 32'h7F80_0000;
                    flg_d = 3'b010;
                end else if (e_fin <= 10'sd0) begin
                    res_d = 32'h0;
                    flg_d = 3'b001;
                end else begin
                    res_d = {1'b0, e_fin[7:0], frac_fin};
                    flg_d = 3'b000;
                end
            end
            DONE: if (ov_q && io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            man_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            ov_q    <= ov_d;
        end
    end
endmodule

// File: tb/tb_fp_square.sv
// Directed and random checks of fp_square against an integer-arithmetic reference.
module tb_fp_square;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nchk = 0;
    int   nbad = 0;

    fp_square_if bus();
    fp_square dut (.clk(clk), .rst_n(rst_n), .io(bus));

    always #5 clk = ~clk;

`ifdef FP_SQUARE_ROUND_EN
    localparam logic [31:0] RND_WANT = 32'h4010_0002;
`else
    localparam logic [31:0] RND_WANT = 32'h4010_0001;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        assert (got === want) else begin
            nbad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Reference: exact integer square, scale to a 24-bit significand, then round/clip.
    function automatic void model(input logic [31:0] x, output logic [31:0] r, output logic [2:0] f);
        int unsigned       e;
        longint unsigned   m, p, q, rem, half;
        int                ex, s;
        e = x[30:23];
        if (e == 255) begin
            r = (x[22:0] != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
            f = (x[22:0] != 0) ? 3'b100 : 3'b000;
        end else if (e == 0) begin
            r = 32'h0; f = 3'b000;
        end else begin
            m  = 64'h80_0000 + longint'(x[22:0]);
            p  = m * m;
            ex = 2 * int'(e) - 127;
            s  = 23;
            if (p >= (64'd1 << 47)) begin ex++; s = 24; end
            q    = p >> s;
            rem  = p - (q << s);
            half = 64'd1 << (s - 1);
`ifdef FP_SQUARE_ROUND_EN
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin q = 64'd1 << 23; ex++; end
`else
            if (rem > half) q = q;
`endif
            if (ex >= 255)    begin r = 32'h7F80_0000; f = 3'b010; end
            else if (ex <= 0) begin r = 32'h0;         f = 3'b001; end
            else begin
                r = {1'b0, 8'(ex), 23'(q)};
                f = 3'b000;
            end
        end
    endfunction

    task automatic apply(input logic [31:0] x, input logic [31:0] want_r,
                         input logic [2:0] want_f, input int hold);
        int          lat, edges;
        logic [31:0] r0;
        logic [2:0]  f0;
        lat   = (x[30:23] == 8'h00 || x[30:23] == 8'hFF) ? 1 : 26;
        edges = 0;
        @(negedge clk);
        while (!bus.in_ready && edges < 50) begin @(negedge clk); edges++; end
        chk("ready_before", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.floating_point_in = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.floating_point_in = $urandom;
        edges = 0;
        chk("busy_ready", 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && edges < 100) begin @(posedge clk); #1; edges++; end
        chk("latency", edges, lat);
        chk("result", bus.result, want_r);
        chk("flags", 32'(bus.flags), 32'(want_f));
        nvec++;
        r0 = bus.result;
        f0 = bus.flags;
        repeat (hold) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.floating_point_in = $urandom;
            @(posedge clk); #1;
            chk("hold_result", bus.result, r0);
            chk("hold_flags", 32'(bus.flags), 32'(f0));
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] x, r;
        logic [2:0]  f;
        logic        seen;
        bus.in_valid = 1'b0;
        bus.floating_point_in = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.in_ready), 32'd1);

        apply(32'h4040_0000, 32'h4110_0000, 3'b000, 5);
        apply(32'hC000_0000, 32'h4080_0000, 3'b000, 0);
        apply(32'h7FC0_0001, 32'h7FC0_0000, 3'b100, 0);
        apply(32'hFF80_0000, 32'h7F80_0000, 3'b000, 0);
        apply(32'h0000_0001, 32'h0000_0000, 3'b000, 0);
        apply(32'h7F00_0000, 32'h7F80_0000, 3'b010, 0);
        apply(32'h1F80_0000, 32'h0000_0000, 3'b001, 0);
        apply(32'h3FC0_0001, RND_WANT,      3'b000, 0);

        // abort an operation mid-multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.floating_point_in = 32'h4040_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        chk("abort_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            if (i % 4 == 0) x[30:23] = 8'(63 + $urandom_range(0, 129));
            model(x, r, f);
            apply(x, r, f, i % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_square.md
FP_SQUARE -- requirements
Module: fp_square

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port `in_valid`, input, 1 bit: operand on `floating_point_in` is valid.
REQ-004 The block SHALL have the port `in_ready`, output, 1 bit: block accepts an operand; high only in IDLE.
REQ-005 The block SHALL have the port `floating_point_in`, input, 32 bits: IEEE-754 single-precision operand x.
REQ-006 The block SHALL have the port `out_valid`, output, 1 bit: `result` and `flags` are valid; high only in DONE.
REQ-007 The block SHALL have the port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-008 The block SHALL have the port `result`, output, 32 bits: IEEE-754 single-precision x*x.
REQ-009 The block SHALL have the port `flags`, output, 3 bits: bit 2 invalid (NaN in), bit 1 overflow, bit 0 underflow.

Function
REQ-010 The block SHALL accept an operand on a rising edge where in_valid && in_ready, capturing floating_point_in into an internal register.
REQ-011 The FSM SHALL have exactly four states, IDLE, MUL, NORM and DONE, with the following transitions:
- IDLE->MUL on acceptance of a normal operand;
- IDLE->DONE on acceptance of a special operand;
- MUL->NORM after 24 iterations;
- NORM->DONE;
- DONE->IDLE on out_ready.
REQ-012 In MUL, the block SHALL compute the 48-bit product of {1,mantissa} by itself using shift-add, one multiplier bit per cycle, with a 5-bit iteration counter from 23 down to 0.
REQ-013 For a normal operand, out_valid SHALL rise exactly 26 clock edges after the acceptance edge.
REQ-014 For a special operand, out_valid SHALL rise on the edge immediately after the acceptance edge.
REQ-015 Special operands SHALL be handled as follows:
- NaN input: result 0x7FC00000, flags 3'b100.
- ±infinity input: result 0x7F800000, flags 3'b000.
- ±0 or denormal input (exponent 0): result 0x00000000, flags 3'b000; denormals are flushed to zero.
REQ-016 The sign of the result SHALL always be 0, regardless of input sign.
REQ-017 Exponent computation SHALL be done in 10-bit signed arithmetic: e_res = 2*e - 127 + n, where n = 1 if product[47] = 1.
- When n = 1, the mantissa SHALL be taken from product[46:24].
- When n = 0, the mantissa SHALL be taken from product[45:23].
REQ-018 If e_res >= 255 after normalisation and rounding, the result SHALL be 0x7F800000 and flags SHALL be 3'b010.
REQ-019 If e_res <= 0, the result SHALL be 0x00000000 and flags SHALL be 3'b001.
REQ-020 While in DONE, result and flags SHALL be held stable until the handshake completes; DONE with out_ready high returns to IDLE on that edge.
REQ-021 in_valid SHALL be ignored whenever the FSM is not in IDLE; there is no input buffering.
REQ-022 The block SHALL NOT accept a new operand in the same cycle that it returns from DONE to IDLE; acceptance is possible at the earliest on the following edge.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously force the following:
- state to IDLE;
- out_valid to 0;
- result to 32'h0;
- flags to 3'b000;
- iteration counter and product register to 0.
REQ-024 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-025 Reset asserted mid-operation (MUL, NORM or DONE) SHALL abort the operation; no result is produced for the aborted operand.

Configuration
REQ-026 With macro FP_SQUARE_ROUND_EN defined, NORM SHALL perform round-to-nearest-even using guard and sticky bits from the discarded product bits.
- A mantissa carry-out SHALL increment the exponent and re-check overflow.
- NORM SHALL remain exactly 1 cycle, so latency is unchanged.
REQ-027 Without FP_SQUARE_ROUND_EN, NORM SHALL truncate the discarded bits (round toward zero).

Verification
REQ-028 Normal path: input 0x40400000 (3.0) -> result 0x41100000 (9.0), flags 0, out_valid exactly 26 edges after acceptance.
REQ-029 Sign and exponent carry: input 0xC0000000 (-2.0) -> result 0x40800000.
REQ-030 Special cases, each with out_valid one edge after acceptance:
- 0x7FC00001 -> 0x7FC00000, flags 3'b100;
- 0xFF800000 -> 0x7F800000;
- 0x00000001 -> 0x00000000.
REQ-031 Range limits:
- Input 0x7F000000 -> result 0x7F800000, flags 3'b010.
- Input 0x1F800000 -> result 0x00000000, flags 3'b001.
REQ-032 Rounding: input 0x3FC00001 -> result 0x40100002 with FP_SQUARE_ROUND_EN, 0x40100001 without.
REQ-033 Handshake and reset:
- Hold out_ready low for 5 cycles in DONE -> result stable and in_ready low throughout.
- Pulse rst_n low during MUL -> out_valid stays 0 and in_ready returns 1 after release.
